vc_arbiter: RTL and testbench
=============================

# vc_arbiter

Weighted arbiter and router between the VC0/VC1 virtual-channel FIFOs and the two destination FIFOs (D0/D1) of the PCIe transmit path. It peeks at the head word of each VC FIFO and decides the destination from that word. It issues single-word reads only when the target destination has room, then forwards the read word to D0 or D1 with a registered push. VC0 is preferred with a programmable weight; VC1 is guaranteed service.

## Interface
- data_width, 6, word width; bit [data_width-1] is the destination select (0 = D0, 1 = D1)
- weight_vc0, 3, max consecutive VC0 grants while VC1 is eligible (1..15)

- clk  in  1  single clock, all logic on posedge
- reset  in  1  asynchronous, active-high; clears all state
- init  in  1  synchronous enable; 0 = hold in INIT state
- vc0_empty, vc1_empty  in  1  VC FIFO empty flags (combinational from FIFO count)
- vc0_head, vc1_head  in  data_width  VC FIFO registered head peek (mem[rd_ptr], updated one cycle after rd_ptr moves)
- vc0_data, vc1_data  in  data_width  VC FIFO read data, valid the cycle after rd_enable
- d0_almost_full, d1_almost_full  in  1  destination almost-full
- d0_full, d1_full  in  1  destination full
- vc0_rd_enable, vc1_rd_enable  out  1  registered read strobes, mutually exclusive
- d0_push, d1_push  out  1  registered write strobes, mutually exclusive
- data_out  out  data_width  registered word to destinations
- idle  out  1  1 when state is IDLE
- error  out  1  sticky; a push was issued while the target d*_full was 1

## Operation
- Reset values: all outputs 0 except idle = 0. State = INIT, weight counter = 0, pending = 0.
- States: INIT, IDLE, ACTIVE.
  - Any state -> INIT when init = 0. Transition is synchronous; it clears the pipeline, counters and error.
  - INIT -> IDLE when init = 1.
  - IDLE -> ACTIVE on any grant.
  - ACTIVE -> IDLE when there is no grant this cycle and no pending push.
- Eligibility of VCx at cycle N requires all three:
  - vcx_empty = 0 in cycle N and in cycle N-1. The head peek lags a fresh write by one cycle.
  - VCx was not read in cycle N-1. The head peek is stale for one cycle after a read.
  - The destination of vcx_head has almost_full = 0.
- Grant, one per cycle at most:
  - Only one VC eligible: grant it.
  - Both eligible: grant VC0 if count < weight_vc0, else VC1.
  - count increments on each VC0 grant, saturating at weight_vc0. It clears on each VC1 grant.
- A grant registers vcx_rd_enable = 1 for exactly one cycle. The destination bit of the head is stored alongside it as pending (1 flop + 1 dest bit + 1 source bit).
- Pending capture: in the cycle after rd_enable, vcx_data is registered into data_out, and d0_push or d1_push is set per the stored destination bit. The push is asserted for one cycle.
- The destination is taken from the head peek at grant time, not from the read data. A mismatch between that bit and vcx_data[data_width-1] sets error.
- error sets on a push while the matching d*_full = 1. It clears only in INIT or on reset.

## Timing
- Grant decision in cycle N → rd_enable high in N+1 → FIFO data valid in N+2 → push/data_out high in N+3.
- Read-to-push latency is 2 cycles.
- Throughput:
  - Alternating VCs: 1 word/cycle.
  - A single VC alone: 1 word per 2 cycles, due to the stale-head rule.
- Up to 2 words are in flight per destination. Destination almost_full thresholds must leave ≥ 2 free slots.
- Simultaneous events:
  - almost_full rising while a word is pending does not cancel that push.
  - A new grant may issue in the same cycle a pending push completes.
- Reset mid-operation: outputs go to 0 immediately and in-flight words are discarded.
- init = 0 mid-operation: from the next edge, rd_enable, push and data_out are 0 and pending is dropped.

## Test plan
- Reset then init = 1, both VCs empty → idle = 1, no rd_enable, error = 0.
- VC0 holds heads 6'h05, 6'h06 and D0 is open → vc0_rd_enable in two cycles 2 apart. d0_push with data_out 6'h05 and 6'h06 arrives 2 cycles after each read. No d1_push.
- Both VCs hold 8 words, all to D1, weight_vc0 = 3 → grant order is VC0, VC1, VC0, VC1, ... (stale-head gaps). Count never blocks VC0 until it reaches 3 with VC1 eligible.
- VC1 head 6'h25 (dest D1) with d1_almost_full = 1 → no vc1_rd_enable. Drop almost_full → read on the next decision cycle; push appears 2 cycles after the read.
- Force d0_full = 1 on the cycle of a pending d0_push → error = 1 and stays 1 until init = 0.
- Assert reset between rd_enable and push → no push occurs, all outputs 0. After reset release plus init = 1, state is IDLE.

Source files
------------

// File: rtl/vc_arbiter.sv
// Weighted two-VC arbiter/router: peeks VC FIFO heads, issues single-word reads
// and forwards the returned word to D0/D1 with a registered push.
module vc_arbiter #(
    parameter int data_width = 6,
    parameter int weight_vc0 = 3
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  init,
    input  logic                  vc0_empty,
    input  logic                  vc1_empty,
    input  logic [data_width-1:0] vc0_head,
    input  logic [data_width-1:0] vc1_head,
    input  logic [data_width-1:0] vc0_data,
    input  logic [data_width-1:0] vc1_data,
    input  logic                  d0_almost_full,
    input  logic                  d1_almost_full,
    input  logic                  d0_full,
    input  logic                  d1_full,
    output logic                  vc0_rd_enable,
    output logic                  vc1_rd_enable,
    output logic                  d0_push,
    output logic                  d1_push,
    output logic [data_width-1:0] data_out,
    output logic                  idle,
    output logic                  error
);
    localparam int msb = data_width - 1;
    localparam logic [3:0] weight_c = 4'(weight_vc0);

    typedef enum logic [1:0] {
        INIT   = 2'd0,
        IDLE   = 2'd1,
        ACTIVE = 2'd2
    } state_t;

    state_t                       state_reg, state_next;
    logic [1:0]                   empty_vec, empty_prev_reg, af_vec, full_vec;
    logic [1:0]                   elig, dest_vec;
    logic [1:0][data_width-1:0]   head_vec, data_vec;
    logic [1:0]                   rd_reg, push_reg;
    logic                         s1_dst_reg;
    logic                         s2_valid_reg, s2_src_reg, s2_dst_reg;
    logic [data_width-1:0]        data_reg, cap_data;
    logic [3:0]                   cnt_reg;
    logic                         error_reg;
    logic                         can_grant, grant0, grant1, any_grant;
    logic                         pending, push_err, data_err;

    assign empty_vec = {vc1_empty, vc0_empty};
    assign af_vec    = {d1_almost_full, d0_almost_full};
    assign full_vec  = {d1_full, d0_full};
    assign head_vec  = {vc1_head, vc0_head};
    assign data_vec  = {vc1_data, vc0_data};

    // A VC needs two non-empty cycles (head peek lags writes) and must not
    // have a read in flight this cycle (head peek stale after a read).
    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_vc
            assign dest_vec[gi] = head_vec[gi][msb];
            assign elig[gi]     = ~empty_vec[gi] & ~empty_prev_reg[gi] &
                                  ~rd_reg[gi] & ~af_vec[dest_vec[gi]];
        end
    endgenerate

    assign can_grant = init && (state_reg != INIT);
    assign grant0    = can_grant & elig[0] & (~elig[1] | (cnt_reg < weight_c));
    assign grant1    = can_grant & elig[1] & ~grant0;
    assign any_grant = grant0 | grant1;
    assign pending   = (|rd_reg) | s2_valid_reg;

    assign cap_data  = data_vec[s2_src_reg];
    assign push_err  = |(push_reg & full_vec);
    assign data_err  = s2_valid_reg & (cap_data[msb] != s2_dst_reg);

    always_comb begin
        state_next = state_reg;
        if (!init) begin
            state_next = INIT;
        end else begin
            case (state_reg)
                INIT:    state_next = IDLE;
                IDLE:    if (any_grant) state_next = ACTIVE;
                ACTIVE:  if (!any_grant && !pending) state_next = IDLE;
                default: state_next = INIT;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg      <= INIT;
            empty_prev_reg <= 2'b11;
            rd_reg         <= 2'b00;
            s1_dst_reg     <= 1'b0;
            s2_valid_reg   <= 1'b0;
            s2_src_reg     <= 1'b0;
            s2_dst_reg     <= 1'b0;
            push_reg       <= 2'b00;
            data_reg       <= '0;
            cnt_reg        <= 4'd0;
            error_reg      <= 1'b0;
        end else begin
            state_reg      <= state_next;
            empty_prev_reg <= empty_vec;
            if (!init) begin
                rd_reg       <= 2'b00;
                s1_dst_reg   <= 1'b0;
                s2_valid_reg <= 1'b0;
                s2_src_reg   <= 1'b0;
                s2_dst_reg   <= 1'b0;
                push_reg     <= 2'b00;
                data_reg     <= '0;
                cnt_reg      <= 4'd0;
                error_reg    <= 1'b0;
            end else begin
                // Destination comes from the head peek at grant time.
                rd_reg       <= {grant1, grant0};
                s1_dst_reg   <= grant1 ? dest_vec[1] : dest_vec[0];
                s2_valid_reg <= |rd_reg;
                s2_src_reg   <= rd_reg[1];
                s2_dst_reg   <= s1_dst_reg;
                push_reg     <= {s2_valid_reg & s2_dst_reg, s2_valid_reg & ~s2_dst_reg};
                data_reg     <= s2_valid_reg ? cap_data : '0;
                if (grant1) begin
                    cnt_reg <= 4'd0;
                end else if (grant0 && (cnt_reg < weight_c)) begin
                    cnt_reg <= cnt_reg + 4'd1;
                end
                error_reg    <= error_reg | push_err | data_err;
            end
        end
    end

    assign vc0_rd_enable = rd_reg[0];
    assign vc1_rd_enable = rd_reg[1];
    assign d0_push       = push_reg[0];
    assign d1_push       = push_reg[1];
    assign data_out      = data_reg;
    assign idle          = (state_reg == IDLE);
    assign error         = error_reg;
endmodule

// File: tb/tb_vc_arbiter.sv
// Bench for vc_arbiter: behavioural FIFO sources, a grant-history model checked
// every cycle, and directed scenarios with literal expectations.
module tb_vc_arbiter;
    localparam int DW = 6;
    localparam int WT = 3;

    logic          clk = 1'b0;
    logic          reset, init;
    logic          vc0_empty, vc1_empty;
    logic [DW-1:0] vc0_head, vc1_head, vc0_data, vc1_data;
    logic          d0_almost_full, d1_almost_full, d0_full, d1_full;
    logic          vc0_rd_enable, vc1_rd_enable, d0_push, d1_push;
    logic [DW-1:0] data_out;
    logic          idle, error;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    vc_arbiter #(.data_width(DW), .weight_vc0(WT)) dut (
        .clk(clk), .reset(reset), .init(init),
        .vc0_empty(vc0_empty), .vc1_empty(vc1_empty),
        .vc0_head(vc0_head), .vc1_head(vc1_head),
        .vc0_data(vc0_data), .vc1_data(vc1_data),
        .d0_almost_full(d0_almost_full), .d1_almost_full(d1_almost_full),
        .d0_full(d0_full), .d1_full(d1_full),
        .vc0_rd_enable(vc0_rd_enable), .vc1_rd_enable(vc1_rd_enable),
        .d0_push(d0_push), .d1_push(d1_push),
        .data_out(data_out), .idle(idle), .error(error)
    );

    always #5 clk = ~clk;

    // Behavioural source FIFOs: combinational empty/head, data one cycle after read.
    logic [DW-1:0] fmem [2][64];
    int            wr_p [2];
    int            rd_p [2];
    logic [DW-1:0] fdata [2];

    initial begin
        wr_p[0] = 0; wr_p[1] = 0;
        rd_p[0] = 0; rd_p[1] = 0;
        fdata[0] = '0; fdata[1] = '0;
    end

    assign vc0_empty = (rd_p[0] == wr_p[0]);
    assign vc1_empty = (rd_p[1] == wr_p[1]);
    assign vc0_head  = fmem[0][rd_p[0] & 63];
    assign vc1_head  = fmem[1][rd_p[1] & 63];
    assign vc0_data  = fdata[0];
    assign vc1_data  = fdata[1];

    always @(posedge clk) begin
        if (vc0_rd_enable && !vc0_empty) begin
            fdata[0] <= fmem[0][rd_p[0] & 63];
            rd_p[0]  <= rd_p[0] + 1;
        end
        if (vc1_rd_enable && !vc1_empty) begin
            fdata[1] <= fmem[1][rd_p[1] & 63];
            rd_p[1]  <= rd_p[1] + 1;
        end
    end

    task automatic add_word(input int v, input logic [DW-1:0] w);
        fmem[v][wr_p[v] & 63] = w;
        wr_p[v] = wr_p[v] + 1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s cyc=%0d actual=%0h required=%0h", name, cyc, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // DUT activity log used by the directed literal checks.
    int rd_cyc_q[$], rd_src_q[$], push_cyc_q[$], push_dst_q[$], push_dat_q[$];

    task automatic clear_logs();
        rd_cyc_q.delete(); rd_src_q.delete();
        push_cyc_q.delete(); push_dst_q.delete(); push_dat_q.delete();
    endtask

    // Model: a ring of recent grant decisions indexed by cycle. A grant made in
    // cycle t shows as a read in t+1 and as a push in t+3 carrying the word the
    // source returned in t+2.
    logic          hv [8];
    int            hs [8];
    logic          hd [8];
    logic [DW-1:0] hcap [8];
    int            m_state;   // 0 = init, 1 = idle, 2 = active
    int            m_cnt;
    logic          m_err;
    logic [1:0]    m_pe;

    always @(negedge clk) begin : model
        int            i0, i1, i2, i3, g;
        logic [1:0]    er, ep, emp, af, hdb, el;
        logic [DW-1:0] edata;
        logic          eidle, eerr, err_n;
        i0 = cyc & 7; i1 = (cyc - 1) & 7; i2 = (cyc - 2) & 7; i3 = (cyc - 3) & 7;
        if (reset) begin
            er = 2'b00; ep = 2'b00; edata = '0; eidle = 1'b0; eerr = 1'b0;
        end else begin
            er[0] = hv[i1] && (hs[i1] == 0);
            er[1] = hv[i1] && (hs[i1] == 1);
            ep[0] = hv[i3] && !hd[i3];
            ep[1] = hv[i3] && hd[i3];
            edata = hv[i3] ? hcap[i3] : '0;
            eidle = (m_state == 1);
            eerr  = m_err;
        end
        chk("vc0_rd_enable", vc0_rd_enable, er[0]);
        chk("vc1_rd_enable", vc1_rd_enable, er[1]);
        chk("d0_push", d0_push, ep[0]);
        chk("d1_push", d1_push, ep[1]);
        chk("data_out", data_out, edata);
        chk("idle", idle, eidle);
        chk("error", error, eerr);

        if (vc0_rd_enable) begin rd_cyc_q.push_back(cyc); rd_src_q.push_back(0); end
        if (vc1_rd_enable) begin rd_cyc_q.push_back(cyc); rd_src_q.push_back(1); end
        if (d0_push || d1_push) begin
            push_cyc_q.push_back(cyc);
            push_dst_q.push_back(d1_push ? 1 : 0);
            push_dat_q.push_back(int'(data_out));
            $display("[TB] cyc %0d push d%0d data=%h", cyc, d1_push ? 1 : 0, data_out);
        end

        emp = {vc1_empty, vc0_empty};
        if (reset) begin
            for (int k = 0; k < 8; k++) hv[k] = 1'b0;
            m_state = 0; m_cnt = 0; m_err = 1'b0; m_pe = 2'b11;
        end else begin
            af  = {d1_almost_full, d0_almost_full};
            hdb = {vc1_head[DW-1], vc0_head[DW-1]};
            for (int v = 0; v < 2; v++)
                el[v] = !emp[v] && !m_pe[v] && !er[v] && !af[hdb[v]];
            g = -1;
            if (m_state != 0) begin
                if (el[0] && (!el[1] || m_cnt < WT)) g = 0;
                else if (el[1]) g = 1;
            end
            err_n = m_err | (ep[0] & d0_full) | (ep[1] & d1_full);
            if (hv[i2]) begin
                hcap[i2] = fdata[hs[i2]];
                if (hcap[i2][DW-1] != hd[i2]) err_n = 1'b1;
            end
            if (!init) begin
                for (int k = 0; k < 8; k++) hv[k] = 1'b0;
                m_state = 0; m_cnt = 0; m_err = 1'b0;
            end else begin
                case (m_state)
                    0: m_state = 1;
                    1: if (g >= 0) m_state = 2;
                    default: if (g < 0 && !hv[i1] && !hv[i2]) m_state = 1;
                endcase
                hv[i0] = (g >= 0);
                hs[i0] = (g == 1) ? 1 : 0;
                hd[i0] = (g == 1) ? hdb[1] : hdb[0];
                if (g == 0 && m_cnt < WT) m_cnt = m_cnt + 1;
                if (g == 1) m_cnt = 0;
                m_err = err_n;
            end
            m_pe = emp;
        end
        cyc = cyc + 1;
    end

    int b, c, e, f, g0, h;
    logic [DW-1:0] w;

    initial begin
        reset = 1'b0; init = 1'b0;
        d0_almost_full = 1'b0; d1_almost_full = 1'b0;
        d0_full = 1'b0; d1_full = 1'b0;
        #1 reset = 1'b1;
        tick(2);
        chk("rst_strobes", {vc0_rd_enable, vc1_rd_enable, d0_push, d1_push, idle, error}, 0);
        chk("rst_data", data_out, 0);

        // Empty VCs after init: idle, no reads, no error.
        reset = 1'b0;
        tick(1);
        init = 1'b1;
        tick(4);
        chk("s1_idle", idle, 1);
        chk("s1_rd", {vc1_rd_enable, vc0_rd_enable}, 0);
        chk("s1_err", error, 0);

        // Two VC0 words to D0: reads 2 apart, pushes 2 after each read.
        clear_logs();
        add_word(0, 6'h05); add_word(0, 6'h06);
        b = cyc;
        tick(12);
        chk("s2_nrd", rd_cyc_q.size(), 2);
        chk("s2_npush", push_cyc_q.size(), 2);
        if (rd_cyc_q.size() == 2 && push_cyc_q.size() == 2) begin
            chk("s2_rd0_cyc", rd_cyc_q[0] - b, 2);
            chk("s2_rd_gap", rd_cyc_q[1] - rd_cyc_q[0], 2);
            chk("s2_lat0", push_cyc_q[0] - rd_cyc_q[0], 2);
            chk("s2_lat1", push_cyc_q[1] - rd_cyc_q[1], 2);
            chk("s2_dat0", push_dat_q[0], 32'h05);
            chk("s2_dat1", push_dat_q[1], 32'h06);
            chk("s2_dst", push_dst_q[0] + push_dst_q[1], 0);
        end

        // Both VCs full of D1 words: strict alternation at one read per cycle.
        init = 1'b0;
        tick(1);
        for (int i = 0; i < 8; i++) begin
            w = 6'h20 + 6'(i); add_word(0, w);
            w = 6'h30 + 6'(i); add_word(1, w);
        end
        tick(2);
        clear_logs();
        init = 1'b1;
        c = cyc;
        tick(24);
        chk("s3_nrd", rd_cyc_q.size(), 16);
        chk("s3_npush", push_cyc_q.size(), 16);
        for (int i = 0; i < 16; i++) begin
            if (i < rd_cyc_q.size()) begin
                chk("s3_src", rd_src_q[i], i % 2);
                chk("s3_rd_cyc", rd_cyc_q[i] - c, 2 + i);
            end
            if (i < push_dat_q.size()) begin
                chk("s3_dat", push_dat_q[i], ((i % 2) == 0 ? 32'h20 : 32'h30) + i / 2);
                chk("s3_dst", push_dst_q[i], 1);
            end
        end

        // VC1 head to D1 held back by almost-full, released one decision later.
        clear_logs();
        d1_almost_full = 1'b1;
        add_word(1, 6'h25);
        tick(6);
        chk("s4_blocked", rd_cyc_q.size(), 0);
        d1_almost_full = 1'b0;
        e = cyc;
        tick(6);
        chk("s4_nrd", rd_cyc_q.size(), 1);
        chk("s4_npush", push_cyc_q.size(), 1);
        if (rd_cyc_q.size() == 1 && push_cyc_q.size() == 1) begin
            chk("s4_rd_cyc", rd_cyc_q[0] - e, 1);
            chk("s4_src", rd_src_q[0], 1);
            chk("s4_lat", push_cyc_q[0] - rd_cyc_q[0], 2);
            chk("s4_dat", push_dat_q[0], 32'h25);
            chk("s4_dst", push_dst_q[0], 1);
        end

        // Weight saturation: four VC0 grants, then VC1 wins once it is eligible.
        clear_logs();
        d1_almost_full = 1'b1;
        for (int i = 1; i <= 6; i++) begin
            w = 6'(i); add_word(0, w);
        end
        add_word(1, 6'h2A);
        f = cyc;
        tick(9);
        d1_almost_full = 1'b0;
        tick(15);
        chk("s4b_nrd", rd_cyc_q.size(), 7);
        if (rd_cyc_q.size() == 7) chk("s4b_vc1_pos", rd_src_q[4], 1);

        // Destination full during a push: sticky error until init drops.
        clear_logs();
        add_word(0, 6'h0B);
        g0 = cyc;
        tick(4);
        chk("s5_push_now", d0_push, 1);
        d0_full = 1'b1;
        tick(1);
        d0_full = 1'b0;
        chk("s5_err_set", error, 1);
        tick(3);
        chk("s5_err_hold", error, 1);
        init = 1'b0;
        tick(1);
        chk("s5_err_clr", error, 0);
        init = 1'b1;
        tick(2);

        // Reset between read and push discards the in-flight word.
        clear_logs();
        add_word(0, 6'h11);
        h = cyc;
        tick(2);
        chk("s6_rd", vc0_rd_enable, 1);
        tick(1);
        reset = 1'b1;
        tick(1);
        chk("s6_push", {d1_push, d0_push}, 0);
        chk("s6_data", data_out, 0);
        chk("s6_idle_rst", idle, 0);
        tick(2);
        reset = 1'b0;
        tick(3);
        chk("s6_idle", idle, 1);
        chk("s6_nopush", push_cyc_q.size(), 0);

        tick(2);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
